// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage of the single-issue RISC-V core. Owns the PC, drives the word
//   address into the asynchronous-read instruction ROM, captures the returned
//   word together with its PC into a small FIFO and presents the head entry to
//   decode over a valid/ready handshake. Execute can redirect the PC, which
//   flushes every buffered entry.
//
//   Optional feature (macro FETCH_STATS_EN): adds saturating fetch_count
//   (pops delivered to decode) and redirect_count (redirect cycles) outputs.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_addr       word address into the instruction ROM (fetch_pc[ADDR_W+1:2])
//   imem_rd         instruction word returned combinationally for imem_addr
//   redirect_valid  execute requests a PC change this cycle
//   redirect_pc     redirect target byte address (bits [1:0] ignored)
//   out_valid       head entry valid
//   out_ready       decode accepts the head entry
//   out_instr       head entry instruction word
//   out_pc          head entry byte PC
//   fetch_count     (FETCH_STATS_EN) number of entries handed to decode
//   redirect_count  (FETCH_STATS_EN) number of redirect cycles seen
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rd,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
`ifdef FETCH_STATS_EN
  output logic [31:0]       out_pc,
  output logic [31:0]       fetch_count,
  output logic [15:0]       redirect_count
`else
  output logic [31:0]       out_pc
`endif
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [31:0]      fetch_pc, fetch_pc_n;
  logic [PTR_W:0]   count, count_n;
  logic [PTR_W-1:0] rd_ptr, rd_n, wr_ptr, wr_n;
  logic             pop, push;
  logic             valid_n;
  logic [31:0]      head_instr_n, head_pc_n;

  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] fifo_pc    [DEPTH];

  // Redirect targets are word aligned; the low bits carry no information.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ROM address is a pure slice of the PC, so it wraps modulo 2^ADDR_W.
  assign imem_addr = fetch_pc[ADDR_W+1:2];

  // ---- next-state: handshake, pointers and the next head entry ----
  always_comb begin
    pop          = out_valid & out_ready;
    push         = !redirect_valid & ((count < DEPTH_C) | pop);
    rd_n         = rd_ptr;
    wr_n         = wr_ptr;
    count_n      = count;
    fetch_pc_n   = fetch_pc;
    head_instr_n = out_instr;
    head_pc_n    = out_pc;

    if (redirect_valid) begin
      // Flush wins over any push or pop this cycle.
      rd_n       = '0;
      wr_n       = '0;
      count_n    = '0;
      fetch_pc_n = {redirect_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        wr_n       = wr_ptr + PTR_ONE;
        fetch_pc_n = fetch_pc + 32'd4;
      end
      if (pop) rd_n = rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_n = count + CNT_ONE;
        2'b01:   count_n = count - CNT_ONE;
        default: count_n = count;
      endcase
    end

    valid_n = (count_n != '0);
    // The output registers track whatever will sit at the head after this
    // edge; when the new head is the word being written now, take it from
    // the ROM side instead of the (not yet written) FIFO slot. When the
    // buffer goes empty the outputs simply keep their last value.
    if (valid_n) begin
      if (push && (wr_ptr == rd_n)) begin
        head_instr_n = imem_rd;
        head_pc_n    = fetch_pc;
      end else begin
        head_instr_n = fifo_instr[rd_n];
        head_pc_n    = fifo_pc[rd_n];
      end
    end
  end

  // ---- control and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      fetch_pc  <= fetch_pc_n;
      count     <= count_n;
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_n;
      out_valid <= valid_n;
      out_instr <= head_instr_n;
      out_pc    <= head_pc_n;
    end
  end

  // ---- buffer storage (data only, never observed before being written) ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rd;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

`ifdef FETCH_STATS_EN
  // ---- statistics counters ----
  // A pop in a redirect cycle is discarded, so it is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (pop && !redirect_valid && (fetch_count != '1))
        fetch_count <= fetch_count + 32'd1;
      if (redirect_valid && (redirect_count != '1))
        redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [15:0] redirect_count;
`endif

  logic [31:0] rom [32];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign imem_rd = rom[imem_addr];

  instr_fetch #(.ADDR_W(5), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
`ifdef FETCH_STATS_EN
    .out_pc         (out_pc),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
`else
    .out_pc         (out_pc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, instr);
  endtask

  // reset pulse lasting a fraction of a cycle, called at posedge+1
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check("rst_async_pc", out_pc, 32'd0);
    check("rst_async_addr", {27'd0, imem_addr}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + i;
    rom[0]  = 32'h00300413;
    rom[1]  = 32'h00100493;
    rom[2]  = 32'h01000913;
    rom[16] = 32'hff5ff06f;

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_instr", out_instr, 32'd0);
    check("reset_pc", out_pc, 32'd0);
    check("reset_addr", {27'd0, imem_addr}, 32'd0);
`ifdef FETCH_STATS_EN
    check("reset_fcnt", fetch_count, 32'd0);
    check("reset_rcnt", {16'd0, redirect_count}, 32'd0);
`endif
    step();
    rst_n = 1'b1;

    // Streaming with out_ready held high: one entry per edge
    step(); check_head("stream0", 32'h0, 32'h00300413);
    step(); check_head("stream1", 32'h4, 32'h00100493);
    step(); check_head("stream2", 32'h8, 32'h01000913);

    // Back-pressure from reset: buffer fills and PC stalls
    out_ready = 1'b0;
    pulse_reset();
    step(); check_head("bp0", 32'h0, 32'h00300413);
    step(); check("bp_full_addr", {27'd0, imem_addr}, 32'd2);
    check("bp_full_pc", out_pc, 32'h0);
    step(); check("bp_hold_addr", {27'd0, imem_addr}, 32'd2);
    check_head("bp_hold", 32'h0, 32'h00300413);
    out_ready = 1'b1;
    step(); check_head("bp_drain1", 32'h4, 32'h00100493);
    step(); check_head("bp_drain2", 32'h8, 32'h01000913);
    step(); check_head("bp_drain3", 32'hC, 32'hA000_0003);

    // Redirect with a full buffer and out_ready high in the same cycle
    out_ready = 1'b0;
    pulse_reset();
    step(); step();
    check("rd_full_addr", {27'd0, imem_addr}, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h42; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("rd_bubble_valid", {31'd0, out_valid}, 32'd0);
    check("rd_target_addr", {27'd0, imem_addr}, 32'd16);
`ifdef FETCH_STATS_EN
    check("rd_fcnt", fetch_count, 32'd0);
    check("rd_rcnt", {16'd0, redirect_count}, 32'd1);
`endif
    step(); check_head("rd_target", 32'h40, 32'hff5ff06f);
    step(); check_head("rd_next", 32'h44, 32'hA000_0011);
`ifdef FETCH_STATS_EN
    check("rd_fcnt_after", fetch_count, 32'd1);
`endif

    // Redirect to the top of the address space: PC and ROM index wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check("wrap_bubble", {31'd0, out_valid}, 32'd0);
    check("wrap_addr31", {27'd0, imem_addr}, 32'd31);
    step(); check_head("wrap_top", 32'hFFFF_FFFC, 32'hA000_001F);
    check("wrap_addr0", {27'd0, imem_addr}, 32'd0);
    step(); check_head("wrap_zero", 32'h0, 32'h00300413);

    // Partial-cycle reset with two entries buffered
    out_ready = 1'b0;
    step(); step();
    check("pr_pre_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    pulse_reset();
    step(); check_head("pr_restart0", 32'h0, 32'h00300413);
    step(); check_head("pr_restart1", 32'h4, 32'h00100493);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
